// File: rtl/serial_operand_streamer.sv
// serial_operand_streamer: streams two parallel WIDTH-bit operands LSB-first,
// one bit pair per clock, into a bit-serial adder, then reassembles the
// returned serial sum bits into a (WIDTH+1)-bit result with a done pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request, accepted when idle or in the done cycle
//   a_in/b_in  parallel operands, latched on acceptance
//   ser_a/b    serial operand bits, LSB first (bit WIDTH is a zero pad)
//   ser_valid  serial bits valid this cycle
//   ser_first  marks bit 0 so the adder clears its carry
//   sum_bit    serial sum bit returned by the adder
//   busy       transfer in progress
//   result     reassembled {carry, sum}
//   done       one-cycle pulse, result valid
module serial_operand_streamer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ADDER_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  input  logic             sum_bit,
  output logic             busy,
  output logic [WIDTH:0]   result,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [CW-1:0]    cnt_q;
  logic             vld_dly_q;
  logic             capture_c;

  // Sum bit k is sampled ADDER_LAT edges after the edge that retires bit k.
  assign capture_c = (ADDER_LAT == 0) ? ser_valid : vld_dly_q;

  // Control FSM, serializer and result deserializer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cnt_q     <= '0;
      vld_dly_q <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      vld_dly_q <= ser_valid;
      done      <= 1'b0;

      // Sum bits arrive LSB first, so shift in from the top.
      if (capture_c) begin
        result <= {sum_bit, result[WIDTH:1]};
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Bit 0 goes out directly; the shifters hold bits 1..WIDTH-1
            // with zeros behind them, which supplies the carry pad bit.
            state_q   <= SHIFT;
            sh_a_q    <= a_in >> 1;
            sh_b_q    <= b_in >> 1;
            cnt_q     <= '0;
            ser_a     <= a_in[0];
            ser_b     <= b_in[0];
            ser_valid <= 1'b1;
            ser_first <= 1'b1;
            busy      <= 1'b1;
            result    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end

        SHIFT: begin
          ser_first <= 1'b0;
          if (cnt_q == CW'(WIDTH)) begin
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            ser_valid <= 1'b0;
            if (ADDER_LAT == 0) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            ser_a  <= sh_a_q[0];
            ser_b  <= sh_b_q[0];
            sh_a_q <= sh_a_q >> 1;
            sh_b_q <= sh_b_q >> 1;
            cnt_q  <= cnt_q + CW'(1);
          end
        end

        DRAIN: begin
          state_q <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_streamer.sv
// Bench for serial_operand_streamer: one instance with ADDER_LAT=0 (inst0)
// and one with ADDER_LAT=1 (inst1), each fed by a behavioural serial adder,
// checked every cycle against a transaction-level model of the transfer.
module tb_serial_operand_streamer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;

  logic ser_a_0, ser_b_0, ser_valid_0, ser_first_0, sum_bit_0, busy_0, done_0;
  logic ser_a_1, ser_b_1, ser_valid_1, ser_first_1, sum_bit_1, busy_1, done_1;
  logic [W:0] result_0, result_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_operand_streamer #(.WIDTH(W), .ADDER_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .ser_a(ser_a_0), .ser_b(ser_b_0), .ser_valid(ser_valid_0),
    .ser_first(ser_first_0), .sum_bit(sum_bit_0), .busy(busy_0),
    .result(result_0), .done(done_0)
  );

  serial_operand_streamer #(.WIDTH(W), .ADDER_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .ser_a(ser_a_1), .ser_b(ser_b_1), .ser_valid(ser_valid_1),
    .ser_first(ser_first_1), .sum_bit(sum_bit_1), .busy(busy_1),
    .result(result_1), .done(done_1)
  );

  // Behavioural bit-serial adders: combinational sum (lat 0), registered sum (lat 1).
  logic carry_0_q, carry_1_q, sum_1_q, cin_0, cin_1;
  assign cin_0     = ser_first_0 ? 1'b0 : carry_0_q;
  assign cin_1     = ser_first_1 ? 1'b0 : carry_1_q;
  assign sum_bit_0 = ser_a_0 ^ ser_b_0 ^ cin_0;
  assign sum_bit_1 = sum_1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_0_q <= 1'b0;
      carry_1_q <= 1'b0;
      sum_1_q   <= 1'b0;
    end else begin
      if (ser_valid_0) carry_0_q <= (ser_a_0 & ser_b_0) | (cin_0 & (ser_a_0 ^ ser_b_0));
      if (ser_valid_1) begin
        carry_1_q <= (ser_a_1 & ser_b_1) | (cin_1 & (ser_a_1 ^ ser_b_1));
        sum_1_q   <= ser_a_1 ^ ser_b_1 ^ cin_1;
      end
    end
  end

  // Indexed views of both instances.
  logic [1:0] v_sa, v_sb, v_valid, v_first, v_busy, v_done;
  logic [2*(W+1)-1:0] v_res;
  assign v_sa    = {ser_a_1, ser_a_0};
  assign v_sb    = {ser_b_1, ser_b_0};
  assign v_valid = {ser_valid_1, ser_valid_0};
  assign v_first = {ser_first_1, ser_first_0};
  assign v_busy  = {busy_1, busy_0};
  assign v_done  = {done_1, done_0};
  assign v_res   = {result_1, result_0};

  task automatic check(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d required=%0d t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Transaction model: instance i (adder latency i) accepted at edge e0
  // shows bit n in the cycle after edge e0+n; done after e0+W+1+i.
  int           edge_cnt = 0;
  int           e0     [2];
  int           free_e [2];
  bit           act    [2];
  logic [W-1:0] ma     [2];
  logic [W-1:0] mb     [2];
  logic [W:0]   last   [2];

  always @(posedge clk) begin
    edge_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i]    = 1'b0;
        last[i]   = '0;
        free_e[i] = 0;
      end else begin
        if (act[i] && (edge_cnt - e0[i] > int'(W) + 1 + i)) act[i] = 1'b0;
        if (act[i] && (edge_cnt - e0[i] == int'(W) + 1 + i))
          last[i] = (W+1)'(ma[i]) + (W+1)'(mb[i]);
        if (start && edge_cnt >= free_e[i]) begin
          act[i]    = 1'b1;
          e0[i]     = edge_cnt;
          ma[i]     = a_in;
          mb[i]     = b_in;
          free_e[i] = edge_cnt + int'(W) + 2 + i;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        int n, ev, ea, eb, ef, eby, ed;
        n = edge_cnt - e0[i];
        ev = 0; ea = 0; eb = 0; ef = 0; eby = 0; ed = 0;
        if (act[i]) begin
          ev  = (n <= int'(W)) ? 1 : 0;
          ea  = (n < int'(W)) ? int'(ma[i][n]) : 0;
          eb  = (n < int'(W)) ? int'(mb[i][n]) : 0;
          ef  = (n == 0) ? 1 : 0;
          eby = (n <= int'(W) + i) ? 1 : 0;
          ed  = (n == int'(W) + 1 + i) ? 1 : 0;
        end
        check("ser_valid", i, int'(v_valid[i]), ev);
        check("ser_a",     i, int'(v_sa[i]),    ea);
        check("ser_b",     i, int'(v_sb[i]),    eb);
        check("ser_first", i, int'(v_first[i]), ef);
        check("busy",      i, int'(v_busy[i]),  eby);
        check("done",      i, int'(v_done[i]),  ed);
        if (eby == 0) check("result", i, int'(v_res[i*(W+1) +: W+1]), int'(last[i]));
      end
    end
  end

  task automatic go_idle();
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // One transfer with literal expectations; optional start pulse while busy.
  task automatic xfer(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int exp, input int inj_n);
    int d [2];
    int nd [2];
    int r [2];
    logic [W:0] sa [2];
    logic [W:0] sb [2];
    logic [W:0] sf [2];
    for (int i = 0; i < 2; i++) begin
      d[i] = -1; nd[i] = 0; r[i] = -1; sa[i] = '0; sb[i] = '0; sf[i] = '0;
    end
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n == inj_n) begin
        start = 1'b1; a_in = 4'd15; b_in = 4'd15;
      end else if (n == inj_n + 1) begin
        start = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (n <= int'(W)) begin
          sa[i][n] = v_sa[i];
          sb[i][n] = v_sb[i];
          sf[i][n] = v_first[i];
        end
        if (v_done[i]) begin
          nd[i]++;
          d[i] = n;
          r[i] = int'(v_res[i*(W+1) +: W+1]);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check("done_latency",  i, d[i],  int'(W) + 1 + i);
      check("done_count",    i, nd[i], 1);
      check("result_lit",    i, r[i],  exp);
      check("ser_a_seq",     i, int'(sa[i]), int'({1'b0, a}));
      check("ser_b_seq",     i, int'(sb[i]), int'({1'b0, b}));
      check("ser_first_seq", i, int'(sf[i]), 1);
      check("model_pin",     i, int'(last[i]), exp);
    end
  endtask

  task automatic reset_mid_xfer();
    int nd [2];
    nd[0] = 0; nd[1] = 0;
    start = 1'b1; a_in = 4'd6; b_in = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ser_valid", i, int'(v_valid[i]), 0);
      check("rst_busy",      i, int'(v_busy[i]),  0);
      check("rst_done",      i, int'(v_done[i]),  0);
      check("rst_result",    i, int'(v_res[i*(W+1) +: W+1]), 0);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (v_done[i]) nd[i]++;
    end
    for (int i = 0; i < 2; i++) check("rst_no_done", i, nd[i], 0);
    xfer(4'd5, 4'd9, 14, -1);
  endtask

  // start held through the done cycle: two back-to-back transfers.
  task automatic back_to_back();
    int nd [2];
    int nf [2];
    int d  [2][2];
    int r  [2][2];
    for (int i = 0; i < 2; i++) begin
      nd[i] = 0; nf[i] = 0;
      d[i][0] = -1; d[i][1] = -1; r[i][0] = -1; r[i][1] = -1;
    end
    start = 1'b1; a_in = 4'd2; b_in = 4'd2;
    @(negedge clk);
    a_in = 4'd9; b_in = 4'd8;
    for (int n = 0; n < 18; n++) begin
      if (n == 8) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (v_first[i]) nf[i]++;
        if (v_done[i]) begin
          if (nd[i] < 2) begin
            d[i][nd[i]] = n;
            r[i][nd[i]] = int'(v_res[i*(W+1) +: W+1]);
          end
          nd[i]++;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check("b2b_done_count",  i, nd[i], 2);
      check("b2b_first_count", i, nf[i], 2);
      check("b2b_result0",     i, r[i][0], 4);
      check("b2b_result1",     i, r[i][1], 17);
      check("b2b_done0_at",    i, d[i][0], int'(W) + 1 + i);
      check("b2b_done1_at",    i, d[i][1], 2 * (int'(W) + 1 + i) + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; e0[i] = 0; free_e[i] = 0; last[i] = '0; ma[i] = '0; mb[i] = '0;
    end
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ser_valid", i, int'(v_valid[i]), 0);
      check("reset_busy",      i, int'(v_busy[i]),  0);
      check("reset_done",      i, int'(v_done[i]),  0);
      check("reset_result",    i, int'(v_res[i*(W+1) +: W+1]), 0);
    end
    #2 reset = 1'b0;
    @(negedge clk);

    xfer(4'b0110, 4'b1011, 17, -1);
    go_idle();
    xfer(4'b1111, 4'b1111, 30, -1);
    go_idle();
    xfer(4'b0000, 4'b0000, 0, -1);
    go_idle();
    xfer(4'b1000, 4'b1000, 16, -1);
    go_idle();
    xfer(4'd3, 4'd4, 7, 2);
    go_idle();
    reset_mid_xfer();
    go_idle();
    back_to_back();
    go_idle();

    // Random traffic, including starts while busy and occasional resets.
    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 2) == 0);
      a_in  = W'($urandom_range(0, 15));
      b_in  = W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
      @(negedge clk);
    end
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
